// File: rtl/bmm_feeder.sv
// ---------------------------------------------------------------------------
// bmm_feeder
//   Tile feeder for a blocked matrix multiply. On start it snapshots two
//   SIZE x SIZE matrices. It then presents one output tile pair per transfer,
//   walking the tiles in row-major order. Each tile pair is a BLOCK_SIZE-row
//   strip of A and a BLOCK_SIZE-column strip of B.
//
//   States:
//     state | meaning
//     IDLE  | waiting for start, outputs hold last tile, valid_out=0
//     SEND  | tile (bi,bj) presented with valid_out=1 until ready_in
//     GAP   | one bubble cycle between tiles (BMM_FEEDER_GAP_EN only)
//     FIN   | one-cycle done pulse, then back to IDLE
//
//   Build option:
//     BMM_FEEDER_GAP_EN  when defined, inserts one idle cycle (valid_out=0)
//                        after each accepted non-last tile. Otherwise tiles
//                        are presented back-to-back.
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      start a job (accepted only in IDLE)
//     mat_a      A[r][c] at [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
//     mat_b      B[r][c] at [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
//     ready_in   downstream accepts the current tile
//     A_rows     (i,j) at [(i*SIZE+j)*DW] = A[bi*BLOCK_SIZE+i][j]
//     B_cols     (j,i) at [(j*BLOCK_SIZE+i)*DW] = B[j][bj*BLOCK_SIZE+i]
//     valid_out  tile pair valid
//     tile_row   current bi
//     tile_col   current bj
//     busy       high outside IDLE
//     done       one-cycle pulse at the end of a job
// ---------------------------------------------------------------------------
module bmm_feeder #(
  parameter int BLOCK_SIZE = 2,
  parameter int DATA_WIDTH = 4,
  parameter int SIZE       = 4,
  localparam int NB        = SIZE / BLOCK_SIZE,
  localparam int TW        = (NB > 1) ? $clog2(NB) : 1,
  localparam int MW        = SIZE * SIZE * DATA_WIDTH,
  localparam int TILE_W    = BLOCK_SIZE * SIZE * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MW-1:0]     mat_a,
  input  logic [MW-1:0]     mat_b,
  input  logic              ready_in,
  output logic [TILE_W-1:0] A_rows,
  output logic [TILE_W-1:0] B_cols,
  output logic              valid_out,
  output logic [TW-1:0]     tile_row,
  output logic [TW-1:0]     tile_col,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [TW-1:0] LAST_IDX = TW'(NB - 1);

  // Rows bi*BLOCK_SIZE .. +BLOCK_SIZE-1 of A are contiguous in the flat vector.
  function automatic logic [TILE_W-1:0] rows_of(input logic [MW-1:0] m,
                                                input logic [TW-1:0] bi);
    rows_of = m[int'(bi) * TILE_W +: TILE_W];
  endfunction

  function automatic logic [TILE_W-1:0] cols_of(input logic [MW-1:0] m,
                                                input logic [TW-1:0] bj);
    logic [TILE_W-1:0] c;
    c = '0;
    for (int j = 0; j < SIZE; j++) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        c[(j * BLOCK_SIZE + i) * DATA_WIDTH +: DATA_WIDTH] =
          m[(j * SIZE + int'(bj) * BLOCK_SIZE + i) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
    cols_of = c;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     bi_q, bi_d;
  logic [TW-1:0]     bj_q, bj_d;
  logic [MW-1:0]     mat_a_q, mat_a_d;
  logic [MW-1:0]     mat_b_q, mat_b_d;
  logic [TILE_W-1:0] a_rows_q, a_rows_d;
  logic [TILE_W-1:0] b_cols_q, b_cols_d;
  logic              valid_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    bj_d    = bj_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mat_a_d = mat_a;
          mat_b_d = mat_b;
          bi_d    = '0;
          bj_d    = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_in) begin
          if (bi_q == LAST_IDX && bj_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            if (bj_q == LAST_IDX) begin
              bj_d = '0;
              bi_d = bi_q + 1'b1;
            end else begin
              bj_d = bj_q + 1'b1;
            end
`ifdef BMM_FEEDER_GAP_EN
            state_d = S_GAP;
`else
            state_d = S_SEND;
`endif
          end
        end
      end
      S_GAP:   state_d = S_SEND;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Tile data is precomputed from next-state indices so every output is a flop.
    a_rows_d = rows_of(mat_a_d, bi_d);
    b_cols_d = cols_of(mat_b_d, bj_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bi_q     <= '0;
      bj_q     <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      a_rows_q <= '0;
      b_cols_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bi_q     <= bi_d;
      bj_q     <= bj_d;
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
      a_rows_q <= a_rows_d;
      b_cols_q <= b_cols_d;
      valid_q  <= (state_d == S_SEND);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FIN);
    end
  end

  assign A_rows    = a_rows_q;
  assign B_cols    = b_cols_q;
  assign valid_out = valid_q;
  assign tile_row  = bi_q;
  assign tile_col  = bj_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bmm_feeder.sv
// Directed bench for bmm_feeder at SIZE=4, BLOCK_SIZE=2, DATA_WIDTH=4.
// Build with BMM_FEEDER_GAP_EN defined to check the bubble-cycle variant.
module tb_bmm_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] mat_a;
  logic [63:0] mat_b;
  logic        ready_in;
  logic [31:0] A_rows;
  logic [31:0] B_cols;
  logic        valid_out;
  logic [0:0]  tile_row;
  logic [0:0]  tile_col;
  logic        busy;
  logic        done;

  int n_chk;
  int n_fail;

  localparam logic [63:0] MAT_A_SEQ = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] MAT_B_ID  = 64'h1000_0100_0010_0001;

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];

  bmm_feeder #(.BLOCK_SIZE(2), .DATA_WIDTH(4), .SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .ready_in  (ready_in),
    .A_rows    (A_rows),
    .B_cols    (B_cols),
    .valid_out (valid_out),
    .tile_row  (tile_row),
    .tile_col  (tile_col),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Move to the next tile after an accepted transfer.
  task automatic adv();
    step();
`ifdef BMM_FEEDER_GAP_EN
    chk("gap_valid", 64'(valid_out), 64'd0);
    step();
`endif
  endtask

  task automatic chk_tile(input string tag, input int k);
    chk({tag, "_valid"}, 64'(valid_out), 64'd1);
    chk({tag, "_row"},   64'(tile_row),  64'(k / 2));
    chk({tag, "_col"},   64'(tile_col),  64'(k % 2));
    chk({tag, "_A"},     64'(A_rows),    64'(exp_a[k]));
    chk({tag, "_B"},     64'(B_cols),    64'(exp_b[k]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_A"},     64'(A_rows),    64'd0);
    chk({tag, "_B"},     64'(B_cols),    64'd0);
    chk({tag, "_row"},   64'(tile_row),  64'd0);
    chk({tag, "_col"},   64'(tile_col),  64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_a[0] = 32'h7654_3210; exp_b[0] = 32'h0000_1001;
    exp_a[1] = 32'h7654_3210; exp_b[1] = 32'h1001_0000;
    exp_a[2] = 32'hFEDC_BA98; exp_b[2] = 32'h0000_1001;
    exp_a[3] = 32'hFEDC_BA98; exp_b[3] = 32'h1001_0000;

    rst_n    = 1'b0;
    start    = 1'b0;
    ready_in = 1'b1;
    mat_a    = MAT_A_SEQ;
    mat_b    = MAT_B_ID;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // Job 1: full run, inputs scrambled after capture, start during done.
    start = 1'b1;
    step();
    start = 1'b0;
    mat_a = 64'h0;
    mat_b = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("j1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) adv();
      chk_tile($sformatf("j1_t%0d", k), k);
    end
    step();
    chk("j1_done", 64'(done), 64'd1);
    chk("j1_fin_valid", 64'(valid_out), 64'd0);
    start = 1'b1;
    mat_a = MAT_A_SEQ;
    mat_b = MAT_B_ID;
    step();
    start = 1'b0;
    chk("j1_done_pulse", 64'(done), 64'd0);
    chk("j1_start_at_done_busy", 64'(busy), 64'd0);
    chk("j1_start_at_done_valid", 64'(valid_out), 64'd0);
    step();
    chk("j1_idle_busy", 64'(busy), 64'd0);

    // Job 2: backpressure on tile (0,1), extra start on tile (1,0).
    start = 1'b1;
    step();
    start = 1'b0;
    chk_tile("j2_t0", 0);
    adv();
    chk_tile("j2_t1", 1);
    ready_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_tile($sformatf("j2_stall%0d", s), 1);
    end
    ready_in = 1'b1;
    adv();
    chk_tile("j2_t2", 2);
    start = 1'b1;
    adv();
    start = 1'b0;
    chk_tile("j2_t3", 3);
    step();
    chk("j2_done", 64'(done), 64'd1);
    step();
    chk("j2_done_once", 64'(done), 64'd0);
    chk("j2_no_requeue_busy", 64'(busy), 64'd0);
    step();
    chk("j2_no_requeue_valid", 64'(valid_out), 64'd0);

    // Job 3: reset during tile (0,1), then restart.
    start = 1'b1;
    step();
    start = 1'b0;
    adv();
    chk_tile("j3_t1", 1);
    rst_n = 1'b0;
    #1;
    chk_zero("j3_async_rst");
    step();
    step();
    chk("j3_rst_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("j3_after_rst_busy", 64'(busy), 64'd0);
    chk("j3_after_rst_done", 64'(done), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_tile("j3_restart_t0", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bmm_feeder.md
BMM_FEEDER -- requirements
Module: bmm_feeder

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 2, the tile edge length (BLOCK_SIZE x BLOCK_SIZE output tile).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, the bit width of one matrix element.
REQ-003 SHALL have parameter SIZE, default 4, the full square-matrix edge length; it is an integer multiple of BLOCK_SIZE.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins one job when sampled high in IDLE.
REQ-007 SHALL have port mat_a, input, SIZE*SIZE*DATA_WIDTH bits: element A[r][c] at bits [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port mat_b, input, SIZE*SIZE*DATA_WIDTH bits: element B[r][c] at bits [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port ready_in, input, 1 bit: downstream accepts the current tile; tie high for a consumer without backpressure.
REQ-010 SHALL have port A_rows, output, BLOCK_SIZE*SIZE*DATA_WIDTH bits: element i,j at [(i*SIZE+j)*DATA_WIDTH +: DATA_WIDTH] = A[bi*BLOCK_SIZE+i][j].
REQ-011 SHALL have port B_cols, output, BLOCK_SIZE*SIZE*DATA_WIDTH bits: element j,i at [(j*BLOCK_SIZE+i)*DATA_WIDTH +: DATA_WIDTH] = B[j][bj*BLOCK_SIZE+i].
REQ-012 SHALL have port valid_out, output, 1 bit: A_rows/B_cols hold a valid tile pair.
REQ-013 SHALL have ports tile_row and tile_col, outputs, $clog2(SIZE/BLOCK_SIZE) bits each (minimum 1): current bi and bj.
REQ-014 SHALL have ports busy (1 bit, high outside IDLE) and done (1 bit, one-cycle pulse at job end).

Function
REQ-015 SHALL implement states IDLE, SEND, GAP and FIN.
REQ-016 In IDLE with start=1, SHALL capture mat_a and mat_b into internal registers, set bi=bj=0, and enter SEND; valid_out SHALL rise on the next cycle.
REQ-017 In SEND, SHALL drive valid_out=1 with stable A_rows, B_cols, tile_row and tile_col until valid_out&&ready_in is sampled.
REQ-018 On each accepted transfer, SHALL advance in row-major order: bj increments; bj wraps to 0 after SIZE/BLOCK_SIZE-1 and bi then increments.
REQ-019 The transfer with bi=bj=SIZE/BLOCK_SIZE-1 SHALL be the last one; on its acceptance, SHALL enter FIN.
REQ-020 FIN SHALL assert done=1 for exactly one cycle with valid_out=0, then return to IDLE.
REQ-021 A job SHALL issue exactly (SIZE/BLOCK_SIZE)^2 transfers.
REQ-022 Changes to mat_a/mat_b after capture SHALL not affect the job in progress.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start sampled in the same cycle as the done pulse SHALL be ignored; start is accepted only in IDLE.
REQ-025 With ready_in held low, SHALL hold the same tile indefinitely without advancing.
REQ-026 Outputs SHALL be registered; no combinational path from ready_in to any output.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set valid_out, done, busy, A_rows, B_cols, tile_row, tile_col and bi/bj to 0.
REQ-028 Reset asserted mid-job SHALL abandon the job with no done pulse; a new start is required after release.

Configuration
REQ-029 With macro BMM_FEEDER_GAP_EN defined, each accepted non-last transfer SHALL pass through GAP for one cycle with valid_out=0 before presenting the next tile in SEND.
REQ-030 Without BMM_FEEDER_GAP_EN, GAP SHALL be unreachable and tiles SHALL be presented back-to-back, giving one tile per cycle when ready_in=1.

Verification
REQ-031 Stimulus: SIZE=4, BLOCK_SIZE=2, DATA_WIDTH=4; A[r][c]=(r*4+c) mod 16; B=identity; ready_in=1; start pulse. Response: first tile A_rows=0x76543210, B_cols=0x00001001, tile (0,0).
REQ-032 Stimulus: same job, gap macro off. Response: 4 consecutive valid cycles, tiles (0,0),(0,1),(1,0),(1,1), then done=1 for one cycle; tile (1,1) has A_rows=0xFEDCBA98 and B_cols=0x10010000.
REQ-033 Stimulus: ready_in low for 3 cycles during tile (0,1). Response: tile (0,1) outputs stable for all 3 cycles; advances to tile (1,0) only after ready_in=1.
REQ-034 Stimulus: start pulsed again during tile (1,0). Response: ignored; exactly 4 transfers and a single done pulse.
REQ-035 Stimulus: rst_n low during tile (0,1). Response: all outputs 0 at once and no done; a new start after release restarts at tile (0,0).
REQ-036 Stimulus: BMM_FEEDER_GAP_EN defined, ready_in=1. Response: valid_out pattern 1,0,1,0,1,0,1, then done.
